// File: rtl/i2s_tx_multi.sv
// i2s_tx_multi: FIFO-buffered I2S / TDM serial transmitter.
// Samples enter on a valid/ready stream. They leave MSB-first on SCK/WS/DATA.
// A frame is sent only when a full frame of samples is buffered; otherwise
// the frame is zero-filled and an underrun pulse is raised.
//
// state | meaning
// IDLE  | SCK/WS/DATA held low, divider parked at 0, waiting for enable
// RUN   | frames being serialised; leaves only at a frame boundary
module i2s_tx_multi #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int SLOT_WIDTH   = 32,
    parameter int CHANNELS     = 2,
    parameter int CLK_DIV      = 4,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                        CLK,
    input  logic                        Reset,
    input  logic [3:0]                  AudioControlRegister,
    input  logic [SAMPLE_WIDTH-1:0]     s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic                        DAC_I2S_CLK,
    output logic                        DAC_I2S_WS,
    output logic                        DAC_I2S_DATA,
    output logic                        underrun,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int TOTAL  = SLOT_WIDTH * CHANNELS;
    localparam int IDX_W  = $clog2(TOTAL);
    localparam int SLOT_W = $clog2(SLOT_WIDTH);
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    state_t                   r_state;
    state_t                   w_state_next;

    logic [SAMPLE_WIDTH-1:0]  r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [LVL_W-1:0]         r_level;

    logic [DIV_W-1:0]         r_div;
    logic                     r_sck;
    logic                     r_ws;
    logic [IDX_W-1:0]         r_bit_idx;
    logic [SLOT_W-1:0]        r_slot_cnt;
    logic [SLOT_WIDTH-1:0]    r_shift;
    logic                     r_live;
    logic                     r_underrun;

    logic                     w_enable;
    logic [2:0]               w_atten;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_div_wrap;
    logic                     w_fall;
    logic                     w_frame_end;
    logic                     w_frame_start;
    logic                     w_stop;
    logic                     w_level_ok;
    logic                     w_live;
    logic                     w_slot_start;
    logic [IDX_W-1:0]         w_idx_next;
    logic [IDX_W-1:0]         w_idx_plus;
    logic [SLOT_W-1:0]        w_slot_next;
    logic                     w_ws_next;
    logic signed [SAMPLE_WIDTH-1:0] w_head;
    logic signed [SAMPLE_WIDTH-1:0] w_head_att;
    logic [SLOT_WIDTH-1:0]    w_load;

    assign w_enable    = AudioControlRegister[3];
    assign w_atten     = AudioControlRegister[2:0];
    assign s_ready     = (r_level < LVL_W'(FIFO_DEPTH));
    assign w_push      = s_valid && s_ready;
    assign w_level_ok  = (r_level >= LVL_W'(CHANNELS));
    assign w_div_wrap  = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_fall      = (r_state == ST_RUN) && w_div_wrap && r_sck;
    assign w_frame_end = w_fall && (r_bit_idx == IDX_W'(TOTAL - 1));

    // FSM state register
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // FSM next state: RUN is left only at a frame boundary with enable low
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_enable) w_state_next = ST_RUN;
            ST_RUN:  if (w_frame_end && !w_enable) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: frame start (entry or wrap) and stop at the frame boundary
    always_comb begin
        w_frame_start = 1'b0;
        w_stop        = 1'b0;
        case (r_state)
            ST_IDLE: w_frame_start = w_enable;
            ST_RUN: begin
                w_frame_start = w_frame_end && w_enable;
                w_stop        = w_frame_end && !w_enable;
            end
            default: ;
        endcase
    end

    // Slot bookkeeping, next bit position and next WS level
    always_comb begin
        w_live       = w_frame_start ? w_level_ok : r_live;
        w_slot_start = w_frame_start ||
                       (w_fall && !w_frame_end && (r_slot_cnt == SLOT_W'(SLOT_WIDTH - 1)));
        w_pop        = w_slot_start && w_live;
        w_idx_next   = w_frame_start ? '0 : r_bit_idx + 1'b1;
        w_slot_next  = (w_frame_start || (r_slot_cnt == SLOT_W'(SLOT_WIDTH - 1)))
                       ? '0 : r_slot_cnt + 1'b1;
        w_idx_plus   = (w_idx_next == IDX_W'(TOTAL - 1)) ? '0 : w_idx_next + 1'b1;
        // I2S leads the slot by one bit; TDM marks the final bit of the frame
        if (CHANNELS == 2) w_ws_next = (w_idx_plus >= IDX_W'(SLOT_WIDTH));
        else               w_ws_next = (w_idx_next == IDX_W'(TOTAL - 1));
    end

    // Shifter load: attenuated sample left-justified in the slot, or silence
    always_comb begin
        w_head     = r_mem[r_rd_ptr];
        w_head_att = w_head >>> w_atten;
        w_load     = '0;
        if (w_live) w_load[SLOT_WIDTH-1 -: SAMPLE_WIDTH] = w_head_att;
    end

    // Sample FIFO with occupancy counter; pointers wrap on power-of-two depth
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= s_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_level <= r_level + 1'b1;
            else if (!w_push && w_pop) r_level <= r_level - 1'b1;
        end
    end

    // Bit-clock divider; SCK toggles on every divider wrap while in RUN
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_div <= '0;
            r_sck <= 1'b0;
        end else if ((r_state != ST_RUN) || w_stop) begin
            r_div <= '0;
            r_sck <= 1'b0;
        end else if (w_div_wrap) begin
            r_div <= '0;
            r_sck <= ~r_sck;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Bit/slot position and WS advance on SCK fall or frame start
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_bit_idx  <= '0;
            r_slot_cnt <= '0;
            r_ws       <= 1'b0;
        end else if (w_stop) begin
            r_bit_idx  <= '0;
            r_slot_cnt <= '0;
            r_ws       <= 1'b0;
        end else if (w_frame_start || w_fall) begin
            r_bit_idx  <= w_idx_next;
            r_slot_cnt <= w_slot_next;
            r_ws       <= w_ws_next;
        end
    end

    // Output shifter: load at slot start, shift left on each SCK fall
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset)             r_shift <= '0;
        else if (w_stop)       r_shift <= '0;
        else if (w_slot_start) r_shift <= w_load;
        else if (w_fall)       r_shift <= {r_shift[SLOT_WIDTH-2:0], 1'b0};
    end

    // Live/silent decision per frame and the one-cycle underrun pulse
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_live     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= w_frame_start && !w_level_ok;
            if (w_frame_start) r_live <= w_level_ok;
        end
    end

    assign DAC_I2S_CLK  = r_sck;
    assign DAC_I2S_WS   = r_ws;
    assign DAC_I2S_DATA = r_shift[SLOT_WIDTH-1];
    assign underrun     = r_underrun;
    assign fifo_level   = r_level;

endmodule

// File: tb/tb_i2s_tx_multi.sv
// Directed bench for i2s_tx_multi: a stereo I2S instance (CLK_DIV=2) and a
// 4-slot TDM instance (SLOT_WIDTH=16, CLK_DIV=1), checked frame by frame.
module tb_i2s_tx_multi;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // stereo instance
    logic        reset_s;
    logic [3:0]  ctrl_s;
    logic [15:0] data_s;
    logic        valid_s;
    logic        ready_s, sck_s, ws_s, sd_s, ur_s;
    logic [3:0]  lvl_s;

    // TDM instance
    logic        reset_t;
    logic [3:0]  ctrl_t;
    logic [15:0] data_t;
    logic        valid_t;
    logic        ready_t, sck_t, ws_t, sd_t, ur_t;
    logic [3:0]  lvl_t;

    int n_checks = 0;
    int n_fail   = 0;

    logic cap_ds [0:1023];
    logic cap_ws [0:1023];
    logic cap_dt [0:1023];
    logic cap_wt [0:1023];
    int   ns = 0;
    int   nt = 0;
    int   urc_s = 0;
    int   urc_t = 0;
    int   base;

    i2s_tx_multi #(.SAMPLE_WIDTH(16), .SLOT_WIDTH(32), .CHANNELS(2),
                   .CLK_DIV(2), .FIFO_DEPTH(8)) dut_s (
        .CLK(clk), .Reset(reset_s), .AudioControlRegister(ctrl_s),
        .s_data(data_s), .s_valid(valid_s), .s_ready(ready_s),
        .DAC_I2S_CLK(sck_s), .DAC_I2S_WS(ws_s), .DAC_I2S_DATA(sd_s),
        .underrun(ur_s), .fifo_level(lvl_s));

    i2s_tx_multi #(.SAMPLE_WIDTH(16), .SLOT_WIDTH(16), .CHANNELS(4),
                   .CLK_DIV(1), .FIFO_DEPTH(8)) dut_t (
        .CLK(clk), .Reset(reset_t), .AudioControlRegister(ctrl_t),
        .s_data(data_t), .s_valid(valid_t), .s_ready(ready_t),
        .DAC_I2S_CLK(sck_t), .DAC_I2S_WS(ws_t), .DAC_I2S_DATA(sd_t),
        .underrun(ur_t), .fifo_level(lvl_t));

    // capture what the DAC would latch on each SCK rising edge
    always @(posedge sck_s) begin
        #1;
        if (ns < 1024) begin cap_ds[ns] = sd_s; cap_ws[ns] = ws_s; end
        ns++;
    end

    always @(posedge sck_t) begin
        #1;
        if (nt < 1024) begin cap_dt[nt] = sd_t; cap_wt[nt] = ws_t; end
        nt++;
    end

    always @(negedge clk) begin
        if (ur_s === 1'b1) urc_s++;
        if (ur_t === 1'b1) urc_t++;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int bit_count(input int sel);
        return (sel == 0) ? ns : nt;
    endfunction

    // 64 captured bits starting at off, first transmitted bit in the MSB
    function automatic logic [63:0] pack64(input int sel, input int off);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            case (sel)
                0: r[63-i] = cap_ds[off+i];
                1: r[63-i] = cap_ws[off+i];
                2: r[63-i] = cap_dt[off+i];
                default: r[63-i] = cap_wt[off+i];
            endcase
        end
        return r;
    endfunction

    task automatic wait_bits(input int sel, input int target, input string tag);
        int budget;
        budget = 20000;
        while (bit_count(sel) < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (bit_count(sel) < target) check_val(tag, 64'(bit_count(sel)), 64'(target));
    endtask

    task automatic push_s(input logic [15:0] v);
        data_s  = v;
        valid_s = 1'b1;
        @(negedge clk);
        valid_s = 1'b0;
    endtask

    task automatic push_t(input logic [15:0] v);
        data_t  = v;
        valid_t = 1'b1;
        @(negedge clk);
        valid_t = 1'b0;
    endtask

    initial begin
        reset_s = 1'b1; reset_t = 1'b1;
        ctrl_s = 4'b0000; ctrl_t = 4'b0000;
        data_s = '0; data_t = '0;
        valid_s = 1'b0; valid_t = 1'b0;
        repeat (3) @(negedge clk);
        reset_s = 1'b0; reset_t = 1'b0;
        repeat (4) @(negedge clk);

        check_val("rst_sck",   64'(sck_s),   64'd0);
        check_val("rst_ws",    64'(ws_s),    64'd0);
        check_val("rst_data",  64'(sd_s),    64'd0);
        check_val("rst_ur",    64'(ur_s),    64'd0);
        check_val("rst_ready", 64'(ready_s), 64'd1);
        check_val("rst_level", 64'(lvl_s),   64'd0);

        // frame 1 full-scale samples, frame 2 attenuated by 2
        push_s(16'h8001);
        push_s(16'h7FFE);
        check_val("lvl_two", 64'(lvl_s), 64'd2);
        base   = ns;
        ctrl_s = 4'b1000;
        @(negedge clk);
        check_val("lvl_after_entry", 64'(lvl_s), 64'd1);
        wait_bits(0, base + 40, "timeout_f1");
        check_val("lvl_after_slot1", 64'(lvl_s), 64'd0);
        push_s(16'h8000);
        push_s(16'h4000);
        ctrl_s = 4'b1010;

        // frames 3..5 starve; two samples arrive mid frame 5
        wait_bits(0, base + 4*64 + 10, "timeout_f5");
        push_s(16'h1234);
        push_s(16'hABCD);
        ctrl_s = 4'b1000;
        wait_bits(0, base + 5*64 + 10, "timeout_f6");
        ctrl_s = 4'b0000;
        wait_bits(0, base + 6*64, "timeout_f6_end");
        repeat (40) @(negedge clk);

        check_val("f1_data",  pack64(0, base),        64'h8001_0000_7FFE_0000);
        check_val("f1_ws",    pack64(1, base),        64'h0000_0001_FFFF_FFFE);
        check_val("f2_data",  pack64(0, base + 64),   64'hE000_0000_1000_0000);
        check_val("f3_data",  pack64(0, base + 128),  64'h0);
        check_val("f4_data",  pack64(0, base + 192),  64'h0);
        check_val("f5_data",  pack64(0, base + 256),  64'h0);
        check_val("f6_data",  pack64(0, base + 320),  64'h1234_0000_ABCD_0000);
        check_val("f6_ws",    pack64(1, base + 320),  64'h0000_0001_FFFF_FFFE);
        check_val("ur_count", 64'(urc_s),             64'd3);
        check_val("stop_bits", 64'(ns),               64'(base + 384));
        check_val("idle_sck", 64'(sck_s),             64'd0);
        check_val("idle_ws",  64'(ws_s),              64'd0);

        // fill the FIFO while idle, then run two frames and stop
        for (int k = 0; k < 8; k++) push_s(16'(16'h1111 * (k + 1)));
        check_val("full_ready", 64'(ready_s), 64'd0);
        check_val("full_level", 64'(lvl_s),   64'd8);
        base   = ns;
        ctrl_s = 4'b1000;
        @(negedge clk);
        check_val("pop_ready", 64'(ready_s), 64'd1);
        check_val("pop_level", 64'(lvl_s),   64'd7);
        wait_bits(0, base + 64 + 10, "timeout_r2");
        ctrl_s = 4'b0000;
        wait_bits(0, base + 128, "timeout_r2_end");
        repeat (40) @(negedge clk);
        check_val("r2_f1",     pack64(0, base),      64'h1111_0000_2222_0000);
        check_val("r2_f2",     pack64(0, base + 64), 64'h3333_0000_4444_0000);
        check_val("r2_bits",   64'(ns),              64'(base + 128));
        check_val("r2_level",  64'(lvl_s),           64'd4);
        check_val("r2_ur",     64'(urc_s),           64'd3);

        // TDM: one live frame of four slots, then reset inside a silent frame
        push_t(16'hA5A5);
        push_t(16'h0F0F);
        push_t(16'hFFFF);
        push_t(16'h8000);
        push_t(16'h5555);
        push_t(16'h6666);
        check_val("tdm_level6", 64'(lvl_t), 64'd6);
        base   = nt;
        ctrl_t = 4'b1000;
        wait_bits(1, base + 64 + 21, "timeout_tdm");
        check_val("tdm_data",   pack64(2, base), 64'hA5A5_0F0F_FFFF_8000);
        check_val("tdm_ws",     pack64(3, base), 64'h0000_0000_0000_0001);
        check_val("tdm_ur",     64'(urc_t),      64'd1);
        check_val("tdm_level2", 64'(lvl_t),      64'd2);
        check_val("tdm_sck_hi", 64'(sck_t),      64'd1);
        reset_t = 1'b1;
        #1;
        check_val("arst_sck",   64'(sck_t),   64'd0);
        check_val("arst_ws",    64'(ws_t),    64'd0);
        check_val("arst_data",  64'(sd_t),    64'd0);
        check_val("arst_ur",    64'(ur_t),    64'd0);
        check_val("arst_level", 64'(lvl_t),   64'd0);
        check_val("arst_ready", 64'(ready_t), 64'd1);
        @(negedge clk);
        reset_t = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
